// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - address map and write lane-merge helper for mmio_periph
package mmio_pkg;

  localparam logic [31:0] DUTY_BASE   = 32'hFFFF_FF00;
  localparam logic [31:0] CTRL_ADDR   = 32'hFFFF_FFE8;
  localparam logic [31:0] STATUS_ADDR = 32'hFFFF_FFEC;
  localparam logic [31:0] CMP_ADDR    = 32'hFFFF_FFF0;
  localparam logic [31:0] MICROS_ADDR = 32'hFFFF_FFF4;
  localparam logic [31:0] MILLIS_ADDR = 32'hFFFF_FFF8;

  // size is funct3[1:0]: bit1 = word, bit0 = half, otherwise byte
  function automatic logic [31:0] lane_merge(input logic [1:0]  size,
                                             input logic [1:0]  offset,
                                             input logic [31:0] old_data,
                                             input logic [31:0] new_data);
    logic [31:0] r;
    r = old_data;
    if (size[1]) begin
      r = new_data;
    end else if (size[0]) begin
      if (offset[1]) r[31:16] = new_data[15:0];
      else           r[15:0]  = new_data[15:0];
    end else begin
      case (offset)
        2'd0:    r[7:0]   = new_data[7:0];
        2'd1:    r[15:8]  = new_data[7:0];
        2'd2:    r[23:16] = new_data[7:0];
        default: r[31:24] = new_data[7:0];
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/mmio_periph_if.sv
// rtl/mmio_periph_if.sv - CPU-side write/read bus of the memory-mapped peripheral
interface mmio_periph_if;
  logic        write_mem;
  logic [2:0]  funct3;
  logic [31:0] write_address;
  logic [31:0] write_data;
  logic [31:0] read_address;
  logic [31:0] read_data;

  modport master (
    output write_mem, funct3, write_address, write_data, read_address,
    input  read_data
  );

  modport slave (
    input  write_mem, funct3, write_address, write_data, read_address,
    output read_data
  );
endinterface

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one PWM channel: active duty reloaded at counter wrap, compared to shared counter
module pwm_channel #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] counter,
  input  logic                wrap,
  input  logic [PWM_BITS-1:0] shadow_duty,
  output logic                pwm_out
);
  logic [PWM_BITS-1:0] active;

  // reload only on the last count so the new duty starts cleanly at counter 0
  always_ff @(posedge clk) begin
    if (!rst_n)    active <= '0;
    else if (wrap) active <= shadow_duty;
  end

  assign pwm_out = (counter < active);
endmodule

// File: rtl/mmio_periph.sv
// rtl/mmio_periph.sv - PWM channels, us/ms timers and ms compare interrupt at 0xFFFFFFxx
module mmio_periph
  import mmio_pkg::*;
#(
  parameter int NUM_PWM  = 4,
  parameter int PWM_BITS = 8,
  parameter int CLK_HZ   = 12_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  mmio_periph_if.slave       bus,
  output logic [NUM_PWM-1:0] pwm_out,
  output logic               irq
);
  localparam logic [31:0] US_LAST = 32'(CLK_HZ / 1_000_000 - 1);
  localparam logic [31:0] MS_LAST = 32'(CLK_HZ / 1_000 - 1);

  logic [29:0]         wr_word, rd_word;
  logic [PWM_BITS-1:0] counter;
  logic                wrap;
  logic [31:0]         us_pre, ms_pre, micros, millis, cmp;
  logic                cmp_en, match, cmp_en_d, match_d;
  logic                us_tc, ms_tc, hit, clr;
  logic [31:0]         cmp_merged, ctrl_merged, status_merged, read_d;
  logic [31:0]         duty_rd [NUM_PWM];
  logic                unused_bits;

  assign wr_word = bus.write_address[31:2];
  assign rd_word = bus.read_address[31:2];
  assign wrap    = &counter;
  assign us_tc   = (us_pre == US_LAST);
  assign ms_tc   = (ms_pre == MS_LAST);

  assign cmp_merged    = lane_merge(bus.funct3[1:0], bus.write_address[1:0], cmp, bus.write_data);
  assign ctrl_merged   = lane_merge(bus.funct3[1:0], bus.write_address[1:0], {31'b0, cmp_en}, bus.write_data);
  assign status_merged = lane_merge(bus.funct3[1:0], bus.write_address[1:0], 32'b0, bus.write_data);
  assign unused_bits   = ^{bus.funct3[2], bus.read_address[1:0], ctrl_merged[31:1], status_merged[31:1]};

  // MATCH is only raised by the increment itself, so loading CMP with the current MILLIS never sets it
  assign hit = ms_tc && cmp_en && ((millis + 32'd1) == cmp);
  assign clr = bus.write_mem && (wr_word == STATUS_ADDR[31:2]) && status_merged[0];

  always_comb begin
    match_d  = match;
    cmp_en_d = cmp_en;
    if (hit)      match_d = 1'b1;
    else if (clr) match_d = 1'b0;
    if (bus.write_mem && (wr_word == CTRL_ADDR[31:2])) cmp_en_d = ctrl_merged[0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      counter <= '0;
      us_pre  <= '0;
      ms_pre  <= '0;
      micros  <= '0;
      millis  <= '0;
      cmp     <= '0;
      cmp_en  <= 1'b0;
      match   <= 1'b0;
      irq     <= 1'b0;
    end else begin
      counter <= counter + 1'b1;
      if (us_tc) begin
        us_pre <= '0;
        micros <= micros + 32'd1;
      end else begin
        us_pre <= us_pre + 32'd1;
      end
      if (ms_tc) begin
        ms_pre <= '0;
        millis <= millis + 32'd1;
      end else begin
        ms_pre <= ms_pre + 32'd1;
      end
      if (bus.write_mem && (wr_word == CMP_ADDR[31:2])) cmp <= cmp_merged;
      cmp_en <= cmp_en_d;
      match  <= match_d;
      irq    <= match_d & cmp_en_d;
    end
  end

  for (genvar i = 0; i < NUM_PWM; i++) begin : g_ch
    logic [PWM_BITS-1:0] duty;
    logic [31:0]         merged;
    logic                sel;
    logic                unused_hi;

    assign sel       = bus.write_mem && (wr_word == (DUTY_BASE[31:2] + 30'(i)));
    assign merged    = lane_merge(bus.funct3[1:0], bus.write_address[1:0], 32'(duty), bus.write_data);
    assign unused_hi = ^merged[31:PWM_BITS];
    assign duty_rd[i] = (rd_word == (DUTY_BASE[31:2] + 30'(i))) ? 32'(duty) : 32'd0;

    always_ff @(posedge clk) begin
      if (!rst_n)   duty <= '0;
      else if (sel) duty <= merged[PWM_BITS-1:0];
    end

    pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .counter     (counter),
      .wrap        (wrap),
      .shadow_duty (duty),
      .pwm_out     (pwm_out[i])
    );
  end

  always_comb begin
    read_d = '0;
    for (int i = 0; i < NUM_PWM; i++) read_d = read_d | duty_rd[i];
    case (rd_word)
      MILLIS_ADDR[31:2]: read_d = millis;
      MICROS_ADDR[31:2]: read_d = micros;
      CMP_ADDR[31:2]:    read_d = cmp;
      STATUS_ADDR[31:2]: read_d = {31'b0, match};
      CTRL_ADDR[31:2]:   read_d = {31'b0, cmp_en};
      default:           ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) bus.read_data <= '0;
    else        bus.read_data <= read_d;
  end
endmodule

// File: tb/tb_mmio_periph.sv
// tb/tb_mmio_periph.sv - directed bench with a cycle-count reference model of mmio_periph
module tb_mmio_periph;
  localparam logic [31:0] A_DUTY   = 32'hFFFF_FF00;
  localparam logic [31:0] A_CTRL   = 32'hFFFF_FFE8;
  localparam logic [31:0] A_STATUS = 32'hFFFF_FFEC;
  localparam logic [31:0] A_CMP    = 32'hFFFF_FFF0;
  localparam logic [31:0] A_MICROS = 32'hFFFF_FFF4;
  localparam logic [31:0] A_MILLIS = 32'hFFFF_FFF8;
  localparam logic [2:0]  F_B = 3'b000, F_H = 3'b001, F_W = 3'b010;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] pwm_out;
  logic       irq;
  logic [3:0] unused_pwm16;
  logic       unused_irq16;
  int         vectors = 0;
  int         errs = 0;

  mmio_periph_if bus ();
  mmio_periph_if bus16 ();

  assign bus16.write_mem     = bus.write_mem;
  assign bus16.funct3        = bus.funct3;
  assign bus16.write_address = bus.write_address;
  assign bus16.write_data    = bus.write_data;
  assign bus16.read_address  = bus.read_address;

  mmio_periph #(.NUM_PWM(4), .PWM_BITS(8), .CLK_HZ(12_000_000)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .pwm_out(pwm_out), .irq(irq)
  );

  mmio_periph #(.NUM_PWM(4), .PWM_BITS(16), .CLK_HZ(12_000_000)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(bus16), .pwm_out(unused_pwm16), .irq(unused_irq16)
  );

  always #5 clk = ~clk;

  // model state: everything derived from the number of clock edges since reset release
  int          m_n;
  logic        started = 1'b0;
  logic [31:0] m_micros, m_millis, m_cmp, exp_rd;
  logic        m_en, m_match;
  logic [31:0] shadow [4];
  logic [31:0] period [4];
  logic [31:0] preload_val = 32'd0;
  int          preload_seq = 0;
  int          seen_seq = 0;
  logic [3:0]  e_pwm;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, m_n);
    end
  endtask

  function automatic logic [31:0] m_merge(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] old, input logic [31:0] d);
    int sh;
    logic [31:0] m;
    if (f[1]) return d;
    if (f[0]) begin
      sh = a[1] ? 16 : 0;
      m  = 32'h0000_FFFF << sh;
      return (old & ~m) | ((d & 32'h0000_FFFF) << sh);
    end
    sh = 8 * int'(a[1:0]);
    m  = 32'h0000_00FF << sh;
    return (old & ~m) | ((d & 32'h0000_00FF) << sh);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w >= A_DUTY && w < A_DUTY + 32'd16) return shadow[int'((w - A_DUTY) >> 2)];
    case (w)
      A_MILLIS: return m_millis;
      A_MICROS: return m_micros;
      A_CMP:    return m_cmp;
      A_STATUS: return {31'b0, m_match};
      A_CTRL:   return {31'b0, m_en};
      default:  return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [31:0] w, mg;
    logic set_m, clr_m;
    if (!rst_n) begin
      started  = 1'b1;
      m_n      = 0;
      m_micros = 0;
      m_millis = 0;
      m_cmp    = 0;
      m_en     = 0;
      m_match  = 0;
      exp_rd   = 0;
      for (int c = 0; c < 4; c++) begin shadow[c] = 0; period[c] = 0; end
    end else begin
      exp_rd = model_read(bus.read_address);
      if (preload_seq != seen_seq) begin
        m_micros = preload_val;
        seen_seq = preload_seq;
      end
      m_n++;
      if (m_n % 12 == 0) m_micros = m_micros + 32'd1;
      set_m = 1'b0;
      clr_m = 1'b0;
      if (m_n % 12000 == 0) begin
        m_millis = m_millis + 32'd1;
        set_m = m_en && (m_millis == m_cmp);
      end
      if (m_n % 256 == 0) for (int c = 0; c < 4; c++) period[c] = shadow[c];
      if (bus.write_mem) begin
        w = {bus.write_address[31:2], 2'b00};
        if (w >= A_DUTY && w < A_DUTY + 32'd16) begin
          shadow[int'((w - A_DUTY) >> 2)] =
            m_merge(bus.funct3, bus.write_address, shadow[int'((w - A_DUTY) >> 2)], bus.write_data) & 32'hFF;
        end else if (w == A_CMP) begin
          m_cmp = m_merge(bus.funct3, bus.write_address, m_cmp, bus.write_data);
        end else if (w == A_CTRL) begin
          mg   = m_merge(bus.funct3, bus.write_address, {31'b0, m_en}, bus.write_data);
          m_en = mg[0];
        end else if (w == A_STATUS) begin
          mg    = m_merge(bus.funct3, bus.write_address, 32'd0, bus.write_data);
          clr_m = mg[0];
        end
      end
      if (set_m)      m_match = 1'b1;
      else if (clr_m) m_match = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int c = 0; c < 4; c++) e_pwm[c] = 32'(m_n % 256) < period[c];
      chk("pwm_out", {28'b0, pwm_out}, {28'b0, e_pwm});
      chk("irq", {31'b0, irq}, {31'b0, m_match & m_en});
      chk("read_data", bus.read_data, exp_rd);
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    bus.write_mem     = 1'b1;
    bus.write_address = a;
    bus.write_data    = d;
    bus.funct3        = f;
    @(negedge clk);
    bus.write_mem     = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    bus.read_address = a;
    @(negedge clk);
    chk(nm, bus.read_data, e);
  endtask

  task automatic wait_mod(input int m, input int v);
    int b;
    b = 0;
    while ((m_n % m) != v && b < 70000) begin
      @(negedge clk);
      b++;
    end
    chk("align", 32'(m_n % m), 32'(v));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h [4];
    int hi, b;
    rst_n = 1'b0;
    bus.write_mem = 1'b0;
    bus.funct3 = F_W;
    bus.write_address = 32'd0;
    bus.write_data = 32'd0;
    bus.read_address = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_read", bus.read_data, 32'd0);
    chk("reset_pwm", {28'b0, pwm_out}, 32'd0);
    chk("reset_irq", {31'b0, irq}, 32'd0);
    rst_n = 1'b1;

    repeat (11) @(negedge clk);
    rd_chk("micros_pre", A_MICROS, 32'd0);
    rd_chk("micros_first", A_MICROS, 32'd1);

    wr(A_DUTY + 32'd8, 32'h40, F_W);
    wr(A_DUTY + 32'd4, 32'h00, F_W);
    wr(A_DUTY, 32'hFF, F_W);
    wait_mod(256, 0);
    for (int c = 0; c < 4; c++) h[c] = 0;
    for (int k = 0; k < 256; k++) begin
      for (int c = 0; c < 4; c++) h[c] += int'(pwm_out[c]);
      @(negedge clk);
    end
    chk("pwm2_high", 32'(h[2]), 32'd64);
    chk("pwm1_high", 32'(h[1]), 32'd0);
    chk("pwm0_high", 32'(h[0]), 32'd255);

    wait_mod(256, 128);
    wr(A_DUTY, 32'h10, F_W);
    hi = 0;
    b = 0;
    while ((m_n % 256) != 0 && b < 300) begin
      hi += int'(pwm_out[0]);
      @(negedge clk);
      b++;
    end
    chk("pwm0_tail_old", 32'(hi), 32'd126);
    hi = 0;
    for (int k = 0; k < 256; k++) begin
      hi += int'(pwm_out[0]);
      @(negedge clk);
    end
    chk("pwm0_new", 32'(hi), 32'd16);

    wr(A_DUTY + 32'd12, 32'hAABBCCDD, F_W);
    wr(A_DUTY + 32'd13, 32'h11, F_B);
    rd_chk("duty3_8bit", A_DUTY + 32'd12, 32'h0000_00DD);
    chk("duty3_16bit", bus16.read_data, 32'h0000_11DD);
    rd_chk("unmapped", A_DUTY + 32'd16, 32'd0);
    wr(A_CMP, 32'h1234_5678, F_W);
    wr(A_CMP + 32'd2, 32'hBEEF, F_H);
    rd_chk("cmp_half", A_CMP, 32'hBEEF_5678);
    wr(A_CMP + 32'd3, 32'h00, F_B);
    rd_chk("cmp_byte", A_CMP, 32'h00EF_5678);
    wr(A_CTRL, 32'hFFFF_FFFF, F_W);
    rd_chk("ctrl_mask", A_CTRL, 32'd1);
    wr(A_CTRL, 32'd0, F_W);

    wait_mod(100000, 11999);
    rd_chk("millis_pre", A_MILLIS, 32'd0);
    rd_chk("millis_first", A_MILLIS, 32'd1);

    wr(A_CMP, 32'd3, F_W);
    wr(A_CTRL, 32'd1, F_W);
    b = 0;
    while (irq !== 1'b1 && b < 40000) begin
      @(negedge clk);
      b++;
    end
    chk("irq_rise_edge", 32'(m_n), 32'd36000);
    rd_chk("millis_at_match", A_MILLIS, 32'd3);
    wr(A_STATUS, 32'd0, F_W);
    chk("irq_hold", {31'b0, irq}, 32'd1);
    wr(A_STATUS, 32'd1, F_W);
    chk("irq_clear", {31'b0, irq}, 32'd0);
    wr(A_CMP, 32'd4, F_W);
    wait_mod(100000, 47999);
    wr(A_STATUS, 32'd1, F_W);
    chk("set_beats_clear", {31'b0, irq}, 32'd1);
    wr(A_STATUS, 32'd1, F_W);
    chk("irq_clear2", {31'b0, irq}, 32'd0);
    wr(A_CMP, 32'd4, F_W);
    repeat (20) @(negedge clk);
    chk("cmp_eq_no_set", {31'b0, irq}, 32'd0);

    wait_mod(12, 1);
    force dut.micros = 32'hFFFF_FFFE;
    preload_val = 32'hFFFF_FFFE;
    preload_seq++;
    #1;
    release dut.micros;
    repeat (22) @(negedge clk);
    rd_chk("micros_max", A_MICROS, 32'hFFFF_FFFF);
    rd_chk("micros_wrap", A_MICROS, 32'd0);
    rd_chk("millis_unaffected", A_MILLIS, 32'd4);

    wait_mod(256, 100);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mid_pwm", {28'b0, pwm_out}, 32'd0);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/mmio_periph.md
# mmio_periph

Parametrised memory-mapped peripheral block for the RV32I core. It provides:

- N PWM channels of configurable resolution, with glitch-free duty update;
- free-running microsecond and millisecond timers derived from the clock frequency;
- a millisecond compare-match interrupt.

It sits beside the 8 kB memory array. It decodes the top of the address space (0xFFFFFFxx) and returns a registered 32-bit word to the memory read mux.

## Interface
Parameters:
- NUM_PWM, 4, number of PWM channels (1..16)
- PWM_BITS, 8, duty/counter resolution in bits (1..16)
- CLK_HZ, 12_000_000, clock frequency; must be a multiple of 1_000_000

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  reset, synchronous, active-low
- write_mem  in  1  write strobe
- funct3  in  3  access size: [1]=word, [0]=half, else byte
- write_address  in  32  byte write address
- write_data  in  32  write data, right-aligned for byte/half accesses
- read_address  in  32  byte read address
- read_data  out  32  registered full word at read_address[31:2]; the wrapper does lane extraction
- pwm_out  out  NUM_PWM  active-high PWM outputs
- irq  out  1  compare-match interrupt, level

## Operation

Register map (word addresses; unmapped addresses read 0 and ignore writes):
- 0xFFFFFF00 + 4*i: DUTY[i], R/W, bits [PWM_BITS-1:0]; upper bits read 0
- 0xFFFFFFF8: MILLIS, R
- 0xFFFFFFF4: MICROS, R
- 0xFFFFFFF0: CMP, R/W, millisecond compare value
- 0xFFFFFFEC: STATUS, bit0 MATCH; write 1 clears, write 0 has no effect
- 0xFFFFFFE8: CTRL, bit0 CMP_EN; other bits read 0

Write lane merging:
- Word writes all 4 bytes.
- Half writes write_data[15:0] to the half selected by address[1].
- Byte writes write_data[7:0] to the byte selected by address[1:0].
- Lanes above a register's implemented width are dropped.

PWM:
- One PWM_BITS counter, free-running, shared by all channels; wraps from 2^PWM_BITS-1 to 0.
- Each channel has a shadow duty register (the CPU-visible DUTY[i]) and an active duty register.
- Active duty loads from shadow on the cycle the counter equals 2^PWM_BITS-1, so a new duty takes effect from the counter=0 cycle.
- pwm_out[i] = (counter < active[i]):
  - duty 0 gives constant low;
  - maximum duty gives high for 2^PWM_BITS-1 of every 2^PWM_BITS cycles.

Timers:
- The micro prescaler counts 0..CLK_HZ/1e6-1. At terminal count MICROS increments, mod 2^32.
- The milli prescaler counts 0..CLK_HZ/1e3-1. At terminal count MILLIS increments, mod 2^32.

Compare:
- MATCH sets on the cycle MILLIS increments to a value equal to CMP while CMP_EN=1.
- Writing CMP equal to the current MILLIS does not set MATCH.
- irq = MATCH & CMP_EN.
- If a set and a write-1-clear of MATCH occur in the same cycle, set wins.

## Timing
- Reset (rst_n=0 at a clk edge) gives:
  - all DUTY, active duty, CMP, CTRL, MATCH, MILLIS, MICROS, prescalers and the PWM counter = 0;
  - read_data = 0, pwm_out = 0, irq = 0.
- Reset asserted mid-period truncates the PWM period immediately.
- Read latency is 1 cycle: read_data after edge k reflects read_address sampled at edge k and register contents before that edge's update. A read and a write to the same register in the same cycle return the old value.
- Writes commit at the clk edge where write_mem=1.
- irq rises in the cycle after the MILLIS increment that causes the match, and is registered.
- First MICROS increment occurs CLK_HZ/1e6 cycles after reset release; first MILLIS increment occurs CLK_HZ/1e3 cycles after reset release.

## Structure
- Package mmio_pkg holds:
  - address constants (DUTY_BASE, MILLIS_ADDR, MICROS_ADDR, CMP_ADDR, STATUS_ADDR, CTRL_ADDR);
  - a function computing the 32-bit byte-lane merge from funct3, address[1:0], old and new data.
- Sub-module pwm_channel (parameter PWM_BITS; ports clk, rst_n, counter, wrap, shadow_duty, pwm_out) holds the active-duty register and comparator. It is instantiated NUM_PWM times via generate.

## Test plan
- Reset with all inputs idle, then release rst_n → read_data, pwm_out and irq are 0. With CLK_HZ=12e6, a MICROS read at 12 cycles after release returns 1. MILLIS = 1 after 12000 cycles.
- PWM_BITS=8: write DUTY[2]=0x40 → pwm_out[2] high for exactly 64 of 256 cycles, starting at the first counter wrap after the write. DUTY[1]=0x00 gives constant low; DUTY[0]=0xFF gives high for 255 of 256 cycles.
- Write DUTY[0] mid-period (counter=0x80) → that period finishes with the old duty; the new duty takes effect from the next counter=0.
- Write 0xAABBCCDD to DUTY[3], then sb 0x11 at address offset +1 → DUTY[3] reads 0x000011DD with PWM_BITS=16 and 0x000000DD with PWM_BITS=8.
- Set CMP=3, CTRL=1 → irq rises the cycle after MILLIS becomes 3. Write STATUS=0 → irq stays high. Write STATUS=1 → irq low. Write STATUS=1 in the exact cycle MILLIS increments to CMP again → MATCH remains set.
- Preload MICROS near 0xFFFFFFFF via a test-only force → MICROS wraps to 0, and MILLIS is unaffected.
